led_pwm_modulator: RTL and testbench
====================================

Name: led_pwm_modulator

Overview:
Parametrised multi-channel LED modulator: drives N_CH LED outputs with per-channel PWM duty, a global prescaler and three run modes (fixed PWM, breathing, blink). Successor to the fixed 4-LED modulator top. Sits between the board enable/duty controls and the LED pins. Duty and mode updates are double-buffered and take effect only at PWM period boundaries, so outputs are glitch-free.

Parameters:
N_CH, 4, number of LED channels
PWM_W, 8, PWM counter/duty width; period = 2^PWM_W ticks
PRESCALE, 100, clocks per PWM tick (>=1)
BREATH_STEP, 1, breath-level increment per PWM period
BLINK_PERIODS, 64, PWM periods per blink half-cycle (>=1)

Ports:
clock  in  1  system clock, rising edge
i_reset  in  1  asynchronous reset, active-low
i_enable  in  N_CH  per-channel enable; 0 forces that LED off
i_duty  in  N_CH*PWM_W  per-channel duty; channel k at [k*PWM_W +: PWM_W]
i_load  in  1  strobe: capture i_duty and i_mode into shadow registers
i_mode  in  2  00 fixed PWM, 01 breathe, 10 blink, 11 all off
o_leds  out  N_CH  LED drive, active-high, registered
o_period_end  out  1  one-clock pulse on PWM counter wrap

Behaviour:
- Reset (i_reset=0, async): prescaler, pwm_cnt, shadow/active duty, mode (00), breath level (0, state B_UP), blink counter/phase (0) all cleared; o_leds=0, o_period_end=0.
- Prescaler counts 0..PRESCALE-1; tick asserted on clock where count==PRESCALE-1, then count returns to 0. PRESCALE=1: tick every clock.
- pwm_cnt (PWM_W bits) increments on tick; wraps 2^PWM_W-1 -> 0. Wrap edge = period boundary; o_period_end high exactly one clock after the wrap edge.
- i_load sampled high: shadow duty/mode <= i_duty/i_mode. At each period boundary active <= shadow. i_load on the boundary clock itself: new value lands in shadow, applied at the following boundary.
- Effective duty per channel: mode 00 -> active_duty; 01 -> min(active_duty, breath_level); 10 -> 2^PWM_W-1 when blink_phase=1 and active_duty!=0, else 0; 11 -> 0.
- o_leds[k] <= i_enable[k] & (eff_duty[k] > pwm_cnt); registered, 1-clock latency from pwm_cnt. Duty 0 -> never on; duty 2^PWM_W-1 -> on 2^PWM_W-1 of 2^PWM_W ticks.
- i_enable is not buffered: deassertion forces LED off on the next clock.
- Breath FSM (updates at period boundary, mode 01 only): B_UP: level >= max-BREATH_STEP -> level=max, go B_DOWN; else level += BREATH_STEP. B_DOWN: level <= BREATH_STEP -> level=0, go B_UP; else level -= BREATH_STEP. Any other active mode: level=0, state B_UP. No overflow/underflow permitted.
- Blink: in mode 10, blink_cnt counts periods 0..BLINK_PERIODS-1; at wrap blink_phase toggles. Outside mode 10: blink_cnt=0, blink_phase=1 (first half-cycle after entering blink is on).
- Reset asserted mid-period: all state cleared immediately; after release, first tick after PRESCALE clocks.

Optional Feature:
PWM_PHASE_STAGGER_EN defined: channel k compares against (pwm_cnt + k*(2^PWM_W/N_CH)) mod 2^PWM_W, spreading LED turn-on edges to reduce supply current peaks; duty ratio unchanged. Undefined: all channels compare raw pwm_cnt (turn-on edges aligned at pwm_cnt=0).

Test Plan:
Bench params N_CH=4, PWM_W=4, PRESCALE=2, BREATH_STEP=4, BLINK_PERIODS=2; period = 32 clocks.
1. Reset held, toggle i_enable/i_load -> o_leds=0, o_period_end=0; after release first o_period_end 32 clocks later.
2. Mode 00, duty {0,4,8,15}, enable 1111, i_load -> from next boundary, per period LED0 high 0 clocks, LED1 8, LED2 16, LED3 30; o_period_end every 32 clocks.
3. Mid-period i_load duty 4->12 on LED1 -> current period keeps 8-clock high time; next period 24.
4. Mode 01, duty 15 all -> breath level per period 0,4,8,12,15,11,7,3,0,4 (high clocks x2); B_UP/B_DOWN turnaround with no wrap.
5. Mode 10, duty 8 -> LEDs fully on 2 periods (except final tick), off 2 periods; duty 0 channel stays off; i_enable[2]=0 mid-on-phase -> LED2 low next clock.
6. Async reset pulse mid-period during breathe -> o_leds 0 without clock edge; after release mode 00, level 0.

Source files
------------

// File: rtl/led_pwm_modulator.sv
// Multi-channel LED PWM modulator: prescaled counter, double-buffered duty/mode, fixed/breathe/blink/off modes; `define PWM_PHASE_STAGGER_EN to stagger channel phases.
// o_leds registered one clock after pwm_cnt; no backpressure, shadow updates are applied only at PWM period boundaries.
module led_pwm_modulator #(
  parameter int N_CH          = 4,
  parameter int PWM_W         = 8,
  parameter int PRESCALE      = 100,
  parameter int BREATH_STEP   = 1,
  parameter int BLINK_PERIODS = 64
) (
  input  logic                    clock,
  input  logic                    i_reset,
  input  logic [N_CH-1:0]         i_enable,
  input  logic [N_CH*PWM_W-1:0]   i_duty,
  input  logic                    i_load,
  input  logic [1:0]              i_mode,
  output logic [N_CH-1:0]         o_leds,
  output logic                    o_period_end
);

  localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BLINK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam int MAX_LVL = (2 ** PWM_W) - 1;
  localparam logic [PWM_W-1:0]   DUTY_MAX   = '1;
  localparam logic [PWM_W-1:0]   STEP       = PWM_W'(BREATH_STEP);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIODS - 1);

  typedef enum logic [1:0] {
    M_FIXED   = 2'b00,
    M_BREATHE = 2'b01,
    M_BLINK   = 2'b10,
    M_OFF     = 2'b11
  } mode_t;

  typedef enum logic {
    B_UP   = 1'b0,
    B_DOWN = 1'b1
  } breath_t;

  logic [PRESC_W-1:0]               presc_cnt;
  logic [PWM_W-1:0]                 pwm_cnt;
  logic                             tick;
  logic                             wrap;

  logic [N_CH-1:0][PWM_W-1:0]       shadow_duty;
  logic [N_CH-1:0][PWM_W-1:0]       act_duty;
  mode_t                            shadow_mode;
  mode_t                            act_mode;

  logic [PWM_W-1:0]                 breath_lvl;
  breath_t                          breath_st;
  logic [BLINK_W-1:0]               blink_cnt;
  logic                             blink_phase;

  logic [N_CH-1:0][PWM_W-1:0]       eff_duty;
  logic [N_CH-1:0][PWM_W-1:0]       cmp_cnt;
  logic [N_CH-1:0]                  led_nxt;

  assign tick = (presc_cnt == PRESC_LAST);
  assign wrap = tick && (pwm_cnt == DUTY_MAX);

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
    end
  end

  // A load on the boundary clock lands in shadow after active has already sampled it.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      shadow_duty <= '0;
      shadow_mode <= M_FIXED;
      act_duty    <= '0;
      act_mode    <= M_FIXED;
    end else begin
      if (i_load) begin
        shadow_duty <= i_duty;
        shadow_mode <= mode_t'(i_mode);
      end
      if (wrap) begin
        act_duty <= shadow_duty;
        act_mode <= shadow_mode;
      end
    end
  end

  // Breath level steps on the mode that was active during the period just ending.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      breath_lvl <= '0;
      breath_st  <= B_UP;
    end else if (wrap) begin
      if (act_mode != M_BREATHE) begin
        breath_lvl <= '0;
        breath_st  <= B_UP;
      end else begin
        case (breath_st)
          B_UP: begin
            if (int'(breath_lvl) + BREATH_STEP >= MAX_LVL) begin
              breath_lvl <= DUTY_MAX;
              breath_st  <= B_DOWN;
            end else begin
              breath_lvl <= breath_lvl + STEP;
            end
          end
          B_DOWN: begin
            if (int'(breath_lvl) <= BREATH_STEP) begin
              breath_lvl <= '0;
              breath_st  <= B_UP;
            end else begin
              breath_lvl <= breath_lvl - STEP;
            end
          end
          default: begin
            breath_lvl <= '0;
            breath_st  <= B_UP;
          end
        endcase
      end
    end
  end

  // Phase parks at 1 outside blink so the first half-cycle after entry is lit.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      if (act_mode != M_BLINK) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    eff_duty = '0;
    cmp_cnt  = '0;
    led_nxt  = '0;
    for (int k = 0; k < N_CH; k++) begin
      case (act_mode)
        M_FIXED:   eff_duty[k] = act_duty[k];
        M_BREATHE: eff_duty[k] = (act_duty[k] < breath_lvl) ? act_duty[k] : breath_lvl;
        M_BLINK:   eff_duty[k] = (blink_phase && (act_duty[k] != '0)) ? DUTY_MAX : '0;
        default:   eff_duty[k] = '0;
      endcase
`ifdef PWM_PHASE_STAGGER_EN
      cmp_cnt[k] = pwm_cnt + PWM_W'((k * ((2 ** PWM_W) / N_CH)) % (2 ** PWM_W));
`else
      cmp_cnt[k] = pwm_cnt;
`endif
      led_nxt[k] = i_enable[k] & (eff_duty[k] > cmp_cnt[k]);
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      o_leds       <= '0;
      o_period_end <= 1'b0;
    end else begin
      o_leds       <= led_nxt;
      o_period_end <= wrap;
    end
  end

endmodule

// File: tb/tb_led_pwm_modulator.sv
// Bench for led_pwm_modulator: per-period LED high-time is accumulated and checked against a queue of expected periods.
module tb_led_pwm_modulator;

  localparam int N_CH          = 4;
  localparam int PWM_W         = 4;
  localparam int PRESCALE      = 2;
  localparam int BREATH_STEP   = 4;
  localparam int BLINK_PERIODS = 2;
  localparam int PERIOD_CLKS   = PRESCALE * (2 ** PWM_W);

  logic                  clock = 1'b0;
  logic                  i_reset;
  logic [N_CH-1:0]       i_enable;
  logic [N_CH*PWM_W-1:0] i_duty;
  logic                  i_load;
  logic [1:0]            i_mode;
  logic [N_CH-1:0]       o_leds;
  logic                  o_period_end;

  led_pwm_modulator #(
    .N_CH(N_CH), .PWM_W(PWM_W), .PRESCALE(PRESCALE),
    .BREATH_STEP(BREATH_STEP), .BLINK_PERIODS(BLINK_PERIODS)
  ) dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_duty(i_duty),
    .i_load(i_load), .i_mode(i_mode), .o_leds(o_leds), .o_period_end(o_period_end)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic                  chk;
    logic [N_CH-1:0][7:0]  cnt;
  } exp_t;

  typedef struct packed {
    logic [1:0]            mode;
    logic [N_CH*PWM_W-1:0] duty;
    logic [N_CH-1:0]       en;
    logic [N_CH-1:0][7:0]  cnt;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   acc [N_CH];
  int   cyc = 0;
  int   pidx = 0;

  function automatic exp_t mk(input logic chk, input int c0, input int c1, input int c2, input int c3);
    exp_t e;
    e.chk    = chk;
    e.cnt[0] = 8'(c0);
    e.cnt[1] = 8'(c1);
    e.cnt[2] = 8'(c2);
    e.cnt[3] = 8'(c3);
    return e;
  endfunction

  function automatic logic [15:0] pack(input logic [3:0] d0, input logic [3:0] d1,
                                       input logic [3:0] d2, input logic [3:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic wait_pe();
    bit seen = 1'b0;
    for (int i = 0; i < PERIOD_CLKS + 8; i++) begin
      @(negedge clock);
      if (o_period_end) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL pe_timeout: no o_period_end within %0d clocks", PERIOD_CLKS + 8);
    end
    #1;
  endtask

  task automatic load(input logic [1:0] m, input logic [15:0] d, input logic [3:0] en);
    i_mode   = m;
    i_duty   = d;
    i_enable = en;
    i_load   = 1'b1;
    @(negedge clock);
    #1;
    i_load   = 1'b0;
  endtask

  // Monitor: the sample in the o_period_end cycle is the last one of the ending period.
  always @(negedge clock) begin
    if (!i_reset) begin
      for (int k = 0; k < N_CH; k++) acc[k] = 0;
      cyc = 0;
    end else begin
      cyc++;
      for (int k = 0; k < N_CH; k++) acc[k] += int'(o_leds[k]);
      if (o_period_end) begin
        pidx++;
        n_vec++;
        if (cyc != PERIOD_CLKS) begin
          n_err++;
          $display("FAIL period_len[%0d]: got %0d clocks, want %0d", pidx, cyc, PERIOD_CLKS);
        end
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          if (mon_e.chk) begin
            for (int k = 0; k < N_CH; k++) begin
              n_vec++;
              if (acc[k] != int'(mon_e.cnt[k])) begin
                n_err++;
                $display("FAIL high_clks[%0d] ch%0d: got %0d, want %0d", pidx, k, acc[k], int'(mon_e.cnt[k]));
              end
            end
          end
        end
        for (int k = 0; k < N_CH; k++) acc[k] = 0;
        cyc = 0;
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clock);
    $display("FAIL watchdog: bench did not finish within 20000 clocks");
    $fatal(1, "watchdog");
  end

  vec_t vt [5];
  int   first_pe;
  int   lvl [10];

  initial begin
    vt[0] = '{mode: 2'b00, duty: pack(0, 4, 8, 15),   en: 4'b1111, cnt: {8'd30, 8'd16, 8'd8,  8'd0}};
    vt[1] = '{mode: 2'b00, duty: pack(15, 0, 1, 7),   en: 4'b1011, cnt: {8'd14, 8'd0,  8'd0,  8'd30}};
    vt[2] = '{mode: 2'b11, duty: pack(15, 15, 15, 15), en: 4'b1111, cnt: {8'd0,  8'd0,  8'd0,  8'd0}};
    vt[3] = '{mode: 2'b00, duty: pack(3, 12, 1, 9),   en: 4'b1111, cnt: {8'd18, 8'd2,  8'd24, 8'd6}};
    vt[4] = '{mode: 2'b00, duty: pack(15, 15, 15, 15), en: 4'b0110, cnt: {8'd0,  8'd30, 8'd30, 8'd0}};
    lvl   = '{0, 4, 8, 12, 15, 11, 7, 3, 0, 4};

    i_reset  = 1'b0;
    i_enable = '0;
    i_duty   = 16'hFFFF;
    i_load   = 1'b0;
    i_mode   = 2'b01;

    // Reset held while inputs toggle: outputs stay low and no load is captured.
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check($sformatf("reset_leds[%0d]", i), int'(o_leds), 0);
      check($sformatf("reset_pe[%0d]", i), int'(o_period_end), 0);
      #1;
      i_enable = ~i_enable;
      i_load   = ~i_load;
    end
    i_load   = 1'b0;
    i_enable = 4'b1111;
    sb.push_back(mk(1'b1, 0, 0, 0, 0));
    i_reset  = 1'b1;

    first_pe = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clock);
      if (o_period_end) begin
        first_pe = j;
        break;
      end
    end
    check("first_pe_clocks", first_pe, PERIOD_CLKS);
    #1;

    // Table vectors: load at a boundary, check the period after the next boundary.
    for (int i = 0; i < 5; i++) begin
      load(vt[i].mode, vt[i].duty, vt[i].en);
      sb.push_back((i == 0) ? mk(1'b1, 0, 0, 0, 0) : mk(1'b0, 0, 0, 0, 0));
      sb.push_back(mk(1'b1, int'(vt[i].cnt[0]), int'(vt[i].cnt[1]), int'(vt[i].cnt[2]), int'(vt[i].cnt[3])));
      wait_pe();
      wait_pe();
    end

    // Mid-period load only takes effect at the following boundary.
    load(2'b00, pack(0, 4, 8, 15), 4'b1111);
    sb.push_back(mk(1'b0, 0, 0, 0, 0));
    sb.push_back(mk(1'b1, 0, 8, 16, 30));
    wait_pe();
    repeat (10) @(negedge clock);
    #1;
    load(2'b00, pack(0, 12, 8, 15), 4'b1111);
    sb.push_back(mk(1'b1, 0, 24, 16, 30));
    wait_pe();
    wait_pe();

    // Breathe: levels ramp up, saturate at 15, ramp down to 0 and turn around.
    load(2'b01, pack(15, 15, 15, 15), 4'b1111);
    sb.push_back(mk(1'b1, 0, 24, 16, 30));
    for (int i = 0; i < 10; i++) sb.push_back(mk(1'b1, 2 * lvl[i], 2 * lvl[i], 2 * lvl[i], 2 * lvl[i]));
    repeat (11) wait_pe();

    // Async reset mid-period while breathing at level 8.
    repeat (4) @(negedge clock);
    check("pre_reset_leds", int'(o_leds), 4'hF);
    #1;
    i_reset = 1'b0;
    #1;
    check("async_reset_leds", int'(o_leds), 0);
    check("async_reset_pe", int'(o_period_end), 0);
    repeat (3) @(negedge clock);
    #1;
    i_reset = 1'b1;
    sb.push_back(mk(1'b1, 0, 0, 0, 0));
    wait_pe();

    // Blink: two periods lit, two dark; duty-0 channel stays dark.
    load(2'b10, pack(8, 0, 8, 8), 4'b1111);
    sb.push_back(mk(1'b1, 0, 0, 0, 0));
    sb.push_back(mk(1'b1, 30, 0, 30, 30));
    sb.push_back(mk(1'b1, 30, 0, 30, 30));
    sb.push_back(mk(1'b1, 0, 0, 0, 0));
    sb.push_back(mk(1'b1, 0, 0, 0, 0));
    repeat (5) wait_pe();
    sb.push_back(mk(1'b1, 30, 0, 10, 30));
    repeat (10) @(negedge clock);
    check("led2_before_disable", int'(o_leds[2]), 1);
    #1;
    i_enable = 4'b1011;
    @(negedge clock);
    check("led2_after_disable", int'(o_leds[2]), 0);
    wait_pe();

    repeat (2) @(negedge clock);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
